fetch_stage: RTL and testbench

Parametrised successor to the free-running PC-plus-4 fetch path. Owns the program counter and drives the instruction memory address. Captures the fetched word into an IF/ID pipeline register with a valid bit. Adds reset vector, stall hold, branch/jump redirect with one-bubble flush, misaligned-target flag and a fetch counter; the control unit consumes id_instr.

---
 rtl/rv_pkg.sv | 11 +
 rtl/fetch_stage_pc_reg.sv | 28 ++
 rtl/fetch_stage.sv | 78 +++++++
 tb/tb_fetch_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32 fetch constants.
// Default widths, NOP encoding and PC step size.
package rv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int ILEN_DEF = 32;
    localparam int PC_STEP  = 4;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register.
// Priority: reset vector > target load > hold > step by 4.
module pc_reg
    import rv_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            hold,
    input  logic [XLEN-3:0] target,
    output logic [XLEN-1:0] pc
);

    // PC update; target is word-aligned by dropping byte offset bits
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_VECTOR;
        end else if (load) begin
            pc <= {target, 2'b00};
        end else if (!hold) begin
            pc <= pc + XLEN'(PC_STEP);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register.
// Redirect flushes one bubble; stall freezes the stage.
module fetch_stage
    import rv_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter int              ILEN         = ILEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [ILEN-1:0] NOP_INSTR    = ILEN'(NOP_WORD),
    parameter int              CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [ILEN-1:0]  imem_rdata,
    output logic             id_valid,
    output logic [ILEN-1:0]  id_instr,
    output logic [XLEN-1:0]  id_pc,
    output logic [XLEN-1:0]  id_pc_plus4,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count
);

    logic [XLEN-1:0] pc;
    logic            advance;

    assign advance = !redirect_valid && !stall;

    pc_reg #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc (
        .clk    (clk),
        .rst    (rst),
        .load   (redirect_valid),
        .hold   (stall),
        .target (redirect_target[XLEN-1:2]),
        .pc     (pc)
    );

    assign imem_addr   = pc;
    assign id_pc_plus4 = id_pc + XLEN'(PC_STEP);

    // IF/ID register: flush on redirect, capture on advance
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            id_pc    <= '0;
        end else if (redirect_valid) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
        end else if (!stall) begin
            id_valid <= 1'b1;
            id_instr <= imem_rdata;
            id_pc    <= pc;
        end
    end

    // Sticky misalign flag and captured-instruction counter
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err <= 1'b0;
            fetch_count  <= '0;
        end else begin
            if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
                misalign_err <= 1'b1;
            end
            if (advance) begin
                fetch_count <= fetch_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage.
// Directed plan steps, then random traffic against a step model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          CW  = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        rv = 1'b0;
    logic [31:0] tgt = '0;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        err;
    logic [CW-1:0] cnt;

    logic        h_rst = 1'b1;
    logic [31:0] h_addr;
    logic [31:0] h_rdata;
    logic        h_valid;
    logic [31:0] h_instr;
    logic [31:0] h_pc;
    logic [31:0] h_pc4;
    logic        h_err;
    logic [31:0] h_cnt;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a + 32'h100;
    endfunction

    assign rdata   = mem(addr);
    assign h_rdata = mem(h_addr);

    fetch_stage #(.RESET_VECTOR(32'h0), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (rv),
        .redirect_target (tgt),
        .imem_addr       (addr),
        .imem_rdata      (rdata),
        .id_valid        (id_valid),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .id_pc_plus4     (id_pc4),
        .misalign_err    (err),
        .fetch_count     (cnt)
    );

    fetch_stage #(.RESET_VECTOR(32'hFFFF_FFF8)) dut_hi (
        .clk             (clk),
        .rst             (h_rst),
        .stall           (1'b0),
        .redirect_valid  (1'b0),
        .redirect_target (32'h0),
        .imem_addr       (h_addr),
        .imem_rdata      (h_rdata),
        .id_valid        (h_valid),
        .id_instr        (h_instr),
        .id_pc           (h_pc),
        .id_pc_plus4     (h_pc4),
        .misalign_err    (h_err),
        .fetch_count     (h_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference state
    logic [31:0] m_pc = '0;
    logic        m_valid = 1'b0;
    logic [31:0] m_instr = NOP;
    logic [31:0] m_idpc = '0;
    logic        m_err = 1'b0;
    int          m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic check_all();
        chk("imem_addr", addr, m_pc);
        chk("id_valid", 32'(id_valid), 32'(m_valid));
        chk("id_instr", id_instr, m_instr);
        chk("id_pc", id_pc, m_idpc);
        chk("id_pc_plus4", id_pc4, m_idpc + 32'd4);
        chk("misalign_err", 32'(err), 32'(m_err));
        chk("fetch_count", 32'(cnt), 32'(m_cnt % (1 << CW)));
    endtask

    // one clock: drive at negedge, update model at posedge, check after
    task automatic step(input logic r, input logic s,
                        input logic v, input logic [31:0] t);
        @(negedge clk);
        rst = r;
        stall = s;
        rv = v;
        tgt = t;
        #1;
        chk("addr_pre", addr, m_pc);
        @(posedge clk);
        if (r) begin
            m_pc = 32'h0;
            m_valid = 1'b0;
            m_instr = NOP;
            m_idpc = '0;
            m_err = 1'b0;
            m_cnt = 0;
        end else if (v) begin
            m_pc = t & ~32'h3;
            m_valid = 1'b0;
            m_instr = NOP;
            if (t % 4 != 0) m_err = 1'b1;
        end else if (!s) begin
            m_instr = mem(m_pc);
            m_idpc = m_pc;
            m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
            m_cnt++;
        end
        #1;
        check_all();
    endtask

    initial begin
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0);
            chk("free_pc", id_pc, 32'(i * 4));
            chk("free_instr", id_instr, 32'(i * 4 + 32'h100));
        end
        chk("free_cnt", 32'(cnt), 32'd5);

        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            chk("stall_addr", addr, 32'h8);
            chk("stall_idpc", id_pc, 32'h4);
            chk("stall_cnt", 32'(cnt), 32'd2);
        end
        step(0, 0, 0, 0);
        chk("release_idpc", id_pc, 32'h8);

        step(0, 0, 0, 0);
        chk("pre_redir", addr, 32'h10);
        step(0, 0, 1, 32'h40);
        chk("redir_pc", addr, 32'h40);
        chk("redir_bubble", 32'(id_valid), 32'd0);
        chk("redir_nop", id_instr, NOP);
        step(0, 0, 0, 0);
        chk("redir_tgt_pc", id_pc, 32'h40);
        chk("redir_tgt_v", 32'(id_valid), 32'd1);

        step(0, 1, 1, 32'h80);
        chk("rs_pc", addr, 32'h80);
        chk("rs_bubble", 32'(id_valid), 32'd0);
        step(0, 0, 0, 0);
        chk("rs_idpc", id_pc, 32'h80);

        step(0, 0, 1, 32'h42);
        chk("mis_pc", addr, 32'h40);
        chk("mis_err", 32'(err), 32'd1);
        for (int i = 0; i < 3; i++) step(0, i == 1, 0, 0);
        chk("mis_sticky", 32'(err), 32'd1);

        for (int i = 0; i < 300; i++) begin
            automatic logic r = ($urandom_range(0, 99) < 3);
            automatic logic s = ($urandom_range(0, 99) < 25);
            automatic logic v = ($urandom_range(0, 99) < 15);
            automatic logic [31:0] t = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            step(r, s, v, t);
        end

        chk("hi_reset_addr", h_addr, 32'hFFFF_FFF8);
        chk("hi_reset_v", 32'(h_valid), 32'd0);
        @(negedge clk);
        h_rst = 1'b0;
        @(posedge clk); #1;
        chk("hi_pc0", h_pc, 32'hFFFF_FFF8);
        chk("hi_v0", 32'(h_valid), 32'd1);
        chk("hi_instr0", h_instr, 32'h0000_00F8);
        @(posedge clk); #1;
        chk("hi_pc1", h_pc, 32'hFFFF_FFFC);
        chk("hi_pc4_wrap", h_pc4, 32'h0);
        @(posedge clk); #1;
        chk("hi_pc2", h_pc, 32'h0);
        chk("hi_cnt", h_cnt, 32'd3);
        @(negedge clk);
        h_rst = 1'b1;
        @(posedge clk); #1;
        chk("hi_rst_v", 32'(h_valid), 32'd0);
        chk("hi_rst_addr", h_addr, 32'hFFFF_FFF8);
        chk("hi_rst_instr", h_instr, NOP);
        chk("hi_rst_cnt", h_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
